// File: rtl/vx_fetch_ibuf_pkg.sv
// Shared types and sizing for the per-warp fetch instruction buffer.
// Optional feature macro: VX_IBUF_BYPASS_EN (see vx_fetch_ibuf.sv).
package vx_fetch_ibuf_pkg;

  localparam int unsigned NUM_WARPS = 4;
  localparam int unsigned DEPTH     = 2;
  localparam int unsigned PC_W      = 31;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned UUID_W    = 44;

  localparam int unsigned NW_BITS = $clog2(NUM_WARPS);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [NUM_WARPS-1:0] tmask;
    logic [PC_W-1:0]      pc;
    logic [INSTR_W-1:0]   instr;
    logic [UUID_W-1:0]    uuid;
  } ibuf_entry_t;

endpackage

// File: rtl/vx_fetch_ibuf_if.sv
// Fetch-response and decode-issue signal bundle for vx_fetch_ibuf.
// The buffer itself uses the slave modport; the fetch/decode side uses master.
interface vx_fetch_ibuf_if;
  import vx_fetch_ibuf_pkg::*;

  logic                 fetch_valid;
  logic                 fetch_ready;
  logic [NW_BITS-1:0]   fetch_wid;
  logic [NUM_WARPS-1:0] fetch_tmask;
  logic [PC_W-1:0]      fetch_PC;
  logic [INSTR_W-1:0]   fetch_instr;
  logic [UUID_W-1:0]    fetch_uuid;

  logic                 ibuf_valid;
  logic                 ibuf_ready;
  logic [NW_BITS-1:0]   ibuf_wid;
  logic [NUM_WARPS-1:0] ibuf_tmask;
  logic [PC_W-1:0]      ibuf_PC;
  logic [INSTR_W-1:0]   ibuf_instr;
  logic [UUID_W-1:0]    ibuf_uuid;
  logic [NUM_WARPS-1:0] ibuf_warp_full;

  modport master (
    output fetch_valid, fetch_wid, fetch_tmask, fetch_PC, fetch_instr, fetch_uuid, ibuf_ready,
    input  fetch_ready, ibuf_valid, ibuf_wid, ibuf_tmask, ibuf_PC, ibuf_instr, ibuf_uuid,
    input  ibuf_warp_full
  );

  modport slave (
    input  fetch_valid, fetch_wid, fetch_tmask, fetch_PC, fetch_instr, fetch_uuid, ibuf_ready,
    output fetch_ready, ibuf_valid, ibuf_wid, ibuf_tmask, ibuf_PC, ibuf_instr, ibuf_uuid,
    output ibuf_warp_full
  );

endinterface

// File: rtl/vx_fetch_ibuf_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after rr_ptr+1.
module vx_fetch_ibuf_rr_arbiter
  import vx_fetch_ibuf_pkg::*;
(
  input  logic [NUM_WARPS-1:0] req,
  input  logic [NW_BITS-1:0]   rr_ptr,
  output logic [NUM_WARPS-1:0] grant,
  output logic [NW_BITS-1:0]   grant_idx,
  output logic                 grant_valid
);

  logic [NW_BITS-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    // NUM_WARPS is a power of two, so the add wraps naturally; i == NUM_WARPS checks rr_ptr last.
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx = rr_ptr + NW_BITS'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/vx_fetch_ibuf.sv
// Per-warp instruction buffer between fetch and decode with a registered round-robin issue stage.
// `define VX_IBUF_BYPASS_EN lets a fetch go straight to the output register when all queues are empty.
module vx_fetch_ibuf
  import vx_fetch_ibuf_pkg::*;
(
  input logic           clk,
  input logic           reset,
  vx_fetch_ibuf_if.slave bus
);

  ibuf_entry_t        storage_q [NUM_WARPS][DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q  [NUM_WARPS];
  logic [PTR_W-1:0]   rd_ptr_q  [NUM_WARPS];
  logic [CNT_W-1:0]   count_q   [NUM_WARPS];

  logic [NUM_WARPS-1:0] full, nonempty, push_w, pop_w, grant;
  logic [NW_BITS-1:0]   rr_ptr_q, rr_ptr_d, grant_idx;
  logic                 grant_valid;
  logic                 out_valid_q, out_valid_d;
  logic [NW_BITS-1:0]   out_wid_q, out_wid_d;
  ibuf_entry_t          out_data_q, out_data_d;
  ibuf_entry_t          fetch_entry;
  logic                 push, load, bypass;

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      full[w]     = (count_q[w] == CNT_W'(DEPTH));
      nonempty[w] = (count_q[w] != '0);
    end
  end

  assign fetch_entry = '{tmask: bus.fetch_tmask, pc: bus.fetch_PC,
                         instr: bus.fetch_instr, uuid: bus.fetch_uuid};

  assign bus.fetch_ready = !full[bus.fetch_wid];
  assign push            = bus.fetch_valid && bus.fetch_ready;
  assign load            = !out_valid_q || bus.ibuf_ready;

`ifdef VX_IBUF_BYPASS_EN
  assign bypass = push && load && (nonempty == '0);
`else
  assign bypass = 1'b0;
`endif

  vx_fetch_ibuf_rr_arbiter u_arb (
    .req         (nonempty),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_wid_d   = out_wid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    push_w      = '0;
    pop_w       = '0;
    if (push && !bypass) push_w[bus.fetch_wid] = 1'b1;
    if (load) begin
      if (bypass) begin
        out_valid_d = 1'b1;
        out_wid_d   = bus.fetch_wid;
        out_data_d  = fetch_entry;
        rr_ptr_d    = bus.fetch_wid;
      end else if (grant_valid) begin
        out_valid_d = 1'b1;
        out_wid_d   = grant_idx;
        out_data_d  = storage_q[grant_idx][rd_ptr_q[grant_idx]];
        rr_ptr_d    = grant_idx;
        pop_w       = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Entry storage needs no reset: validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (!reset && push_w[w]) storage_q[w][wr_ptr_q[w]] <= fetch_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        wr_ptr_q[w] <= '0;
        rd_ptr_q[w] <= '0;
        count_q[w]  <= '0;
      end
      rr_ptr_q    <= NW_BITS'(NUM_WARPS - 1);
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_data_q  <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (push_w[w]) wr_ptr_q[w] <= wr_ptr_q[w] + PTR_W'(1);
        if (pop_w[w])  rd_ptr_q[w] <= rd_ptr_q[w] + PTR_W'(1);
        if (push_w[w] && !pop_w[w])      count_q[w] <= count_q[w] + CNT_W'(1);
        else if (!push_w[w] && pop_w[w]) count_q[w] <= count_q[w] - CNT_W'(1);
      end
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_wid_q   <= out_wid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.ibuf_valid     = out_valid_q;
  assign bus.ibuf_wid       = out_wid_q;
  assign bus.ibuf_tmask     = out_data_q.tmask;
  assign bus.ibuf_PC        = out_data_q.pc;
  assign bus.ibuf_instr     = out_data_q.instr;
  assign bus.ibuf_uuid      = out_data_q.uuid;
  assign bus.ibuf_warp_full = full;

endmodule

// File: tb/tb_vx_fetch_ibuf.sv
// Self-checking bench for vx_fetch_ibuf: directed scenarios plus random traffic against a
// queue-based reference model evaluated every cycle.
module tb_vx_fetch_ibuf;
  import vx_fetch_ibuf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_fetch_ibuf_if bus ();

  vx_fetch_ibuf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: one queue per warp plus the output register contents.
  ibuf_entry_t        mq [NUM_WARPS][$];
  logic               m_valid;
  logic [NW_BITS-1:0] m_wid;
  ibuf_entry_t        m_ent;
  int                 m_rr;

  logic [NW_BITS-1:0] issued_wid [$];
  logic [PC_W-1:0]    issued_pc  [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) mq[w].delete();
    m_valid = 1'b0;
    m_wid   = '0;
    m_ent   = '0;
    m_rr    = NUM_WARPS - 1;
  endtask

  task automatic model_update();
    int  w, pick;
    bit  push, load, byp;
    ibuf_entry_t e;
    if (reset) begin
      model_reset();
      return;
    end
    w    = int'(bus.fetch_wid);
    push = bus.fetch_valid && (mq[w].size() < DEPTH);
    load = !m_valid || bus.ibuf_ready;
    pick = -1;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      int c;
      c = (m_rr + i) % NUM_WARPS;
      if (pick < 0 && mq[c].size() > 0) pick = c;
    end
    byp = 1'b0;
`ifdef VX_IBUF_BYPASS_EN
    byp = push && load && (pick < 0);
`endif
    e = '{tmask: bus.fetch_tmask, pc: bus.fetch_PC, instr: bus.fetch_instr,
          uuid: bus.fetch_uuid};
    if (load) begin
      if (byp) begin
        m_valid = 1'b1; m_wid = NW_BITS'(w); m_ent = e; m_rr = w;
      end else if (pick >= 0) begin
        m_valid = 1'b1; m_wid = NW_BITS'(pick); m_ent = mq[pick].pop_front(); m_rr = pick;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (push && !byp) mq[w].push_back(e);
  endtask

  task automatic check_outputs();
    logic [NUM_WARPS-1:0] exp_full;
    for (int w = 0; w < NUM_WARPS; w++) exp_full[w] = (mq[w].size() == DEPTH);
    check("ibuf_valid", bus.ibuf_valid, m_valid);
    check("ibuf_wid", bus.ibuf_wid, m_wid);
    check("ibuf_tmask", bus.ibuf_tmask, m_ent.tmask);
    check("ibuf_PC", bus.ibuf_PC, m_ent.pc);
    check("ibuf_instr", bus.ibuf_instr, m_ent.instr);
    check("ibuf_uuid", bus.ibuf_uuid, m_ent.uuid);
    check("warp_full", bus.ibuf_warp_full, exp_full);
    check("fetch_ready", bus.fetch_ready, mq[int'(bus.fetch_wid)].size() < DEPTH);
  endtask

  // One clock: check at the falling edge, advance the model, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    if (!reset && bus.ibuf_valid && bus.ibuf_ready) begin
      issued_wid.push_back(bus.ibuf_wid);
      issued_pc.push_back(bus.ibuf_PC);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input int wid, input logic [PC_W-1:0] pc,
                           input logic [INSTR_W-1:0] instr);
    bus.fetch_valid = v;
    bus.fetch_wid   = NW_BITS'(wid);
    bus.fetch_tmask = NUM_WARPS'($urandom);
    bus.fetch_PC    = pc;
    bus.fetch_instr = instr;
    bus.fetch_uuid  = {12'($urandom), 32'($urandom)};
  endtask

  task automatic check_issued(input string tag, input int idx, input int exp_wid,
                              input logic [PC_W-1:0] exp_pc);
    logic [NW_BITS-1:0] gw;
    logic [PC_W-1:0]    gp;
    gw = (idx < issued_wid.size()) ? issued_wid[idx] : 'x;
    gp = (idx < issued_pc.size())  ? issued_pc[idx]  : 'x;
    check({tag, "_wid"}, gw, exp_wid);
    check({tag, "_pc"}, gp, exp_pc);
  endtask

  task automatic clear_issued();
    issued_wid.delete();
    issued_pc.delete();
  endtask

  logic [PC_W-1:0]   hold_pc;
  logic [UUID_W-1:0] hold_uuid;

  initial begin
    reset = 1'b1;
    bus.ibuf_ready = 1'b0;
    set_fetch(1'b0, 0, '0, '0);
    model_reset();
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // Single instruction on warp 2
    clear_issued();
    bus.ibuf_ready = 1'b1;
    set_fetch(1'b1, 2, 31'h100, 32'h0000_0013);
    step();
    set_fetch(1'b0, 0, '0, '0);
    repeat (4) step();
    check("single_cnt", issued_wid.size(), 1);
    check_issued("single", 0, 2, 31'h100);
    check("single_drop", bus.ibuf_valid, 1'b0);

    // Three pushes to warp 1 with decode stalled
    clear_issued();
    bus.ibuf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 1, PC_W'(32'h200 + 4 * i), 32'h0000_0013);
      step();
    end
    set_fetch(1'b0, 1, '0, '0);
    step();
    check("w1_full", bus.ibuf_warp_full[1], 1'b1);
    check("w1_ready", bus.fetch_ready, 1'b0);
    bus.fetch_wid = '0;
    #1;
    check("w0_ready", bus.fetch_ready, 1'b1);
    hold_pc   = bus.ibuf_PC;
    hold_uuid = bus.ibuf_uuid;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", bus.ibuf_valid, 1'b1);
      check("stall_pc", bus.ibuf_PC, hold_pc);
      check("stall_uuid", bus.ibuf_uuid, hold_uuid);
    end
    bus.ibuf_ready = 1'b1;
    repeat (6) step();
    check("w1_cnt", issued_wid.size(), 3);
    for (int i = 0; i < 3; i++) check_issued("w1_order", i, 1, PC_W'(32'h200 + 4 * i));

    // One entry per warp, then round-robin drain from warp 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_issued();
    bus.ibuf_ready = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      set_fetch(1'b1, w, PC_W'(32'h300 + 4 * w), 32'h0000_0033);
      step();
    end
    set_fetch(1'b0, 0, '0, '0);
    step();
    bus.ibuf_ready = 1'b1;
    repeat (8) step();
    check("rr_cnt", issued_wid.size(), NUM_WARPS);
    for (int w = 0; w < NUM_WARPS; w++) check_issued("rr_order", w, w, PC_W'(32'h300 + 4 * w));

    // Pointer wrap-around on warp 3
    clear_issued();
    for (int i = 0; i < 10; i++) begin
      set_fetch(1'b1, 3, PC_W'(32'h400 + 4 * i), 32'h0000_0073);
      step();
    end
    set_fetch(1'b0, 0, '0, '0);
    repeat (4) step();
    check("wrap_cnt", issued_wid.size(), 10);
    for (int i = 0; i < 10; i++) check_issued("wrap", i, 3, PC_W'(32'h400 + 4 * i));

    // Reset with work in flight
    bus.ibuf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fetch(1'b1, i % 2, PC_W'(32'h500 + 4 * i), 32'h0000_0013);
      step();
    end
    set_fetch(1'b0, 0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", bus.ibuf_valid, 1'b0);
    check("rst_full", bus.ibuf_warp_full, '0);
    check("rst_ready", bus.fetch_ready, 1'b1);
    clear_issued();
    bus.ibuf_ready = 1'b1;
    repeat (5) step();
    check("rst_stale", issued_wid.size(), 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      set_fetch($urandom_range(0, 9) < 6, $urandom_range(0, NUM_WARPS - 1),
                PC_W'($urandom), $urandom);
      bus.ibuf_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset = 1'b0;
    set_fetch(1'b0, 0, '0, '0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
